// File: rtl/abc80_kbd_pkg.sv
// rtl/abc80_kbd_pkg.sv - shared state type, scancode/ASCII constants and ctrl masking for the ABC80 keyboard
package abc80_kbd_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, HELD} kbd_state_t;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  localparam logic [6:0] CR  = 7'h0D;
  localparam logic [6:0] BS  = 7'h08;
  localparam logic [6:0] TAB = 7'h09;
  localparam logic [6:0] ESC = 7'h1B;

  function automatic logic [6:0] ctrl_mask(input logic [6:0] i_ascii);
    return i_ascii & 7'h1F;
  endfunction

endpackage

// File: rtl/abc80_key_map.sv
// rtl/abc80_key_map.sv - registered set-2 scancode to Swedish-ASCII map; output 0 means unmapped
module abc80_key_map
  import abc80_kbd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ext,
  input  logic [6:0] i_code,
  input  logic       i_shift,
  output logic [6:0] o_ascii
);

  logic [6:0]  w_alpha;
  logic [13:0] w_pair;
  logic [6:0]  w_fixed;
  logic [6:0]  w_ascii;
  logic [6:0]  r_ascii;

  // Letters and åäö (Swedish-ASCII {|} / [\]) shift by clearing bit 5
  always_comb begin
    w_alpha = 7'h00;
    case (i_code)
      7'h1C: w_alpha = 7'h61; 7'h32: w_alpha = 7'h62; 7'h21: w_alpha = 7'h63; 7'h23: w_alpha = 7'h64;
      7'h24: w_alpha = 7'h65; 7'h2B: w_alpha = 7'h66; 7'h34: w_alpha = 7'h67; 7'h33: w_alpha = 7'h68;
      7'h43: w_alpha = 7'h69; 7'h3B: w_alpha = 7'h6A; 7'h42: w_alpha = 7'h6B; 7'h4B: w_alpha = 7'h6C;
      7'h3A: w_alpha = 7'h6D; 7'h31: w_alpha = 7'h6E; 7'h44: w_alpha = 7'h6F; 7'h4D: w_alpha = 7'h70;
      7'h15: w_alpha = 7'h71; 7'h2D: w_alpha = 7'h72; 7'h1B: w_alpha = 7'h73; 7'h2C: w_alpha = 7'h74;
      7'h3C: w_alpha = 7'h75; 7'h2A: w_alpha = 7'h76; 7'h1D: w_alpha = 7'h77; 7'h22: w_alpha = 7'h78;
      7'h35: w_alpha = 7'h79; 7'h1A: w_alpha = 7'h7A; 7'h52: w_alpha = 7'h7B; 7'h4C: w_alpha = 7'h7C;
      7'h54: w_alpha = 7'h7D;
      default: ;
    endcase
  end

  // Digits and punctuation: {unshifted, shifted} per Swedish layout
  always_comb begin
    w_pair = 14'h0000;
    case (i_code)
      7'h16: w_pair = {7'h31, 7'h21}; 7'h1E: w_pair = {7'h32, 7'h22}; 7'h26: w_pair = {7'h33, 7'h23};
      7'h25: w_pair = {7'h34, 7'h24}; 7'h2E: w_pair = {7'h35, 7'h25}; 7'h36: w_pair = {7'h36, 7'h26};
      7'h3D: w_pair = {7'h37, 7'h2F}; 7'h3E: w_pair = {7'h38, 7'h28}; 7'h46: w_pair = {7'h39, 7'h29};
      7'h45: w_pair = {7'h30, 7'h3D}; 7'h41: w_pair = {7'h2C, 7'h3B}; 7'h49: w_pair = {7'h2E, 7'h3A};
      7'h4A: w_pair = {7'h2D, 7'h5F};
      default: ;
    endcase
  end

  always_comb begin
    w_fixed = 7'h00;
    case (i_code)
      7'h5A: w_fixed = CR;
      7'h66: w_fixed = BS;
      7'h76: w_fixed = ESC;
      7'h29: w_fixed = 7'h20;
      default: ;
    endcase
  end

  always_comb begin
    w_ascii = 7'h00;
    if (i_ext) begin
      if (i_code == 7'h6B)      w_ascii = BS;
      else if (i_code == 7'h74) w_ascii = TAB;
    end else if (w_alpha != 7'h00) begin
      w_ascii = i_shift ? (w_alpha & 7'h5F) : w_alpha;
    end else if (w_pair != 14'h0000) begin
      w_ascii = i_shift ? w_pair[6:0] : w_pair[13:7];
    end else begin
      w_ascii = w_fixed;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ascii <= 7'h00;
    else       r_ascii <= w_ascii;
  end

  assign o_ascii = r_ascii;

endmodule

// File: rtl/abc80_keyboard.sv
// rtl/abc80_keyboard.sv - PS/2 key events to ABC80 keyboard port byte; typematic repeat under ABC80_KBD_TYPEMATIC_EN
module abc80_keyboard
  import abc80_kbd_pkg::*;
#(
  parameter int CLK_HZ          = 12_000_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       CLK12,
  input  logic       RESET,
  input  logic       KEY_STROBE,
  input  logic       KEY_PRESSED,
  input  logic       KEY_EXTENDED,
  input  logic [7:0] KEY_CODE,
  input  logic       KEY_ACK,
  output logic [7:0] KB_DATA,
  output logic       KB_DOWN
);

  kbd_state_t r_state;
  logic       r_shift_l, r_shift_r, r_ctrl;
  logic [8:0] r_held;
  logic [7:0] r_kb_data;
  logic       r_kb_down;

  logic [8:0] w_key;
  logic       w_is_lshift, w_is_rshift, w_is_ctrl, w_is_mod;
  logic       w_make, w_new_key, w_held_break, w_mapped;
  logic [6:0] w_rom_ascii, w_char;

  assign w_key        = {KEY_EXTENDED, KEY_CODE};
  assign w_is_lshift  = !KEY_EXTENDED && (KEY_CODE == SC_LSHIFT);
  assign w_is_rshift  = !KEY_EXTENDED && (KEY_CODE == SC_RSHIFT);
  assign w_is_ctrl    = (KEY_CODE == SC_CTRL);
  assign w_is_mod     = w_is_lshift || w_is_rshift || w_is_ctrl;
  assign w_make       = KEY_STROBE && KEY_PRESSED && !w_is_mod;
  assign w_new_key    = w_make && (w_key != r_held);
  assign w_held_break = KEY_STROBE && !KEY_PRESSED && (w_key == r_held);

  // The map is fed the live event so its registered output lines up with LOOKUP
  abc80_key_map u_key_map (
    .i_clk   (CLK12),
    .i_rst   (RESET),
    .i_ext   (KEY_EXTENDED),
    .i_code  (KEY_CODE[6:0]),
    .i_shift (r_shift_l | r_shift_r),
    .o_ascii (w_rom_ascii)
  );

  assign w_mapped = !r_held[7] && (w_rom_ascii != 7'h00);
  assign w_char   = r_ctrl ? ctrl_mask(w_rom_ascii) : w_rom_ascii;

`ifdef ABC80_KBD_TYPEMATIC_EN
  localparam int TICK_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] r_ms_cnt;
  logic [15:0]   r_rep;
  logic          w_tick;

  assign w_tick = (r_ms_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK12 or posedge RESET) begin
    if (RESET)       r_ms_cnt <= '0;
    else if (w_tick) r_ms_cnt <= '0;
    else             r_ms_cnt <= r_ms_cnt + TW'(1);
  end
`else
  logic w_unused_params;
  assign w_unused_params = ^{CLK_HZ[0], REPEAT_DELAY_MS[0], REPEAT_RATE_MS[0]};
`endif

  always_ff @(posedge CLK12 or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_ctrl    <= 1'b0;
      r_held    <= '0;
      r_kb_data <= 8'h00;
      r_kb_down <= 1'b0;
`ifdef ABC80_KBD_TYPEMATIC_EN
      r_rep     <= 16'd0;
`endif
    end else begin
      if (KEY_STROBE && w_is_lshift) r_shift_l <= KEY_PRESSED;
      if (KEY_STROBE && w_is_rshift) r_shift_r <= KEY_PRESSED;
      if (KEY_STROBE && w_is_ctrl)   r_ctrl    <= KEY_PRESSED;

      // A delivery later in this block overrides the ack
      if (KEY_ACK) r_kb_data[7] <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_make) begin
            r_held  <= w_key;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_mapped) begin
            r_kb_data <= {1'b1, w_char};
            r_kb_down <= 1'b1;
`ifdef ABC80_KBD_TYPEMATIC_EN
            r_rep     <= 16'(REPEAT_DELAY_MS);
`endif
            r_state   <= HELD;
          end else begin
            r_kb_down <= 1'b0;
            r_state   <= IDLE;
          end
        end
        HELD: begin
          if (w_new_key) begin
            r_held  <= w_key;
            r_state <= LOOKUP;
          end else if (w_held_break) begin
            r_kb_down <= 1'b0;
            r_state   <= IDLE;
          end
`ifdef ABC80_KBD_TYPEMATIC_EN
          else if (w_tick) begin
            if (r_rep <= 16'd1) begin
              r_kb_data <= {1'b1, r_kb_data[6:0]};
              r_rep     <= 16'(REPEAT_RATE_MS);
            end else begin
              r_rep <= r_rep - 16'd1;
            end
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign KB_DATA = r_kb_data;
  assign KB_DOWN = r_kb_down;

endmodule

// File: tb/tb_abc80_keyboard.sv
// tb/tb_abc80_keyboard.sv - directed self-checking bench for abc80_keyboard (either ABC80_KBD_TYPEMATIC_EN build)
module tb_abc80_keyboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_strobe = 1'b0;
  logic       key_pressed = 1'b0;
  logic       key_extended = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ack = 1'b0;
  logic [7:0] kb_data;
  logic       kb_down;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  abc80_keyboard #(
    .CLK_HZ          (10000),
    .REPEAT_DELAY_MS (3),
    .REPEAT_RATE_MS  (2)
  ) dut (
    .CLK12        (clk),
    .RESET        (rst),
    .KEY_STROBE   (key_strobe),
    .KEY_PRESSED  (key_pressed),
    .KEY_EXTENDED (key_extended),
    .KEY_CODE     (key_code),
    .KEY_ACK      (key_ack),
    .KB_DATA      (kb_data),
    .KB_DOWN      (kb_down)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic ext, input logic [7:0] code, input logic pressed);
    @(negedge clk);
    key_strobe = 1'b1; key_extended = ext; key_code = code; key_pressed = pressed;
    @(negedge clk);
    key_strobe = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk); key_ack = 1'b1;
    @(negedge clk); key_ack = 1'b0;
  endtask

  typedef struct {
    logic       shift;
    logic       ext;
    logic [7:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11] = '{
    '{1'b0, 1'b0, 8'h5A, 8'h8D}, '{1'b0, 1'b0, 8'h66, 8'h88}, '{1'b0, 1'b1, 8'h6B, 8'h88},
    '{1'b0, 1'b0, 8'h76, 8'h9B}, '{1'b0, 1'b0, 8'h29, 8'hA0}, '{1'b0, 1'b0, 8'h45, 8'hB0},
    '{1'b1, 1'b0, 8'h45, 8'hBD}, '{1'b0, 1'b0, 8'h4C, 8'hFC}, '{1'b1, 1'b0, 8'h4C, 8'hDC},
    '{1'b0, 1'b0, 8'h1A, 8'hFA}, '{1'b1, 1'b0, 8'h1A, 8'hDA}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits[$];
    int t[4];
    int pred;

    repeat (3) @(negedge clk);
    check("reset_data", kb_data, 8'h00);
    check("reset_down", kb_down, 1'b0);
    rst = 1'b0;

    // Plain 'a', latency, ack and release
    key(1'b0, 8'h1C, 1'b1);
    check("latency_t1", kb_data, 8'h00);
    @(negedge clk);
    check("a_data", kb_data, 8'hE1);
    check("a_down", kb_down, 1'b1);
    repeat (4) @(negedge clk);
    ack();
    check("a_acked", kb_data, 8'h61);
    key(1'b0, 8'h1C, 1'b0);
    check("a_break_down", kb_down, 1'b0);
    check("a_break_data", kb_data, 8'h61);

    // Unmapped makes, including code[7]=1 aliasing a mapped code
    key(1'b0, 8'h05, 1'b1); repeat (2) @(negedge clk);
    check("unmapped05_data", kb_data, 8'h61);
    check("unmapped05_down", kb_down, 1'b0);
    key(1'b0, 8'h05, 1'b0);
    key(1'b1, 8'h1C, 1'b1); repeat (2) @(negedge clk);
    check("unmapped_e01c", kb_data, 8'h61);
    key(1'b1, 8'h1C, 1'b0);
    key(1'b0, 8'h9C, 1'b1); repeat (2) @(negedge clk);
    check("unmapped_9c", kb_data, 8'h61);
    key(1'b0, 8'h9C, 1'b0);

    // Shift
    key(1'b0, 8'h12, 1'b1);
    check("mod_no_char", kb_data, 8'h61);
    key(1'b0, 8'h1C, 1'b1); @(negedge clk);
    check("shift_a", kb_data, 8'hC1);
    ack();
    key(1'b0, 8'h1C, 1'b0);
    key(1'b0, 8'h12, 1'b0);
    key(1'b0, 8'h32, 1'b1); @(negedge clk);
    check("unshift_b", kb_data, 8'hE2);
    ack();
    key(1'b0, 8'h32, 1'b0);
    key(1'b0, 8'h59, 1'b1);
    key(1'b0, 8'h32, 1'b1); @(negedge clk);
    check("rshift_b", kb_data, 8'hC2);
    ack();
    key(1'b0, 8'h32, 1'b0);
    key(1'b0, 8'h59, 1'b0);

    // Ctrl, key replacement while held, overrun overwrite
    key(1'b0, 8'h14, 1'b1);
    key(1'b0, 8'h23, 1'b1); @(negedge clk);
    check("ctrl_d", kb_data, 8'h84);
    ack();
    key(1'b1, 8'h74, 1'b1); @(negedge clk);
    check("ctrl_tab", kb_data, 8'h89);
    key(1'b0, 8'h5A, 1'b1); @(negedge clk);
    check("ctrl_cr_overrun", kb_data, 8'h8D);
    key(1'b0, 8'h23, 1'b0);
    check("other_break_down", kb_down, 1'b1);
    key(1'b0, 8'h5A, 1'b0);
    check("held_break_down", kb_down, 1'b0);
    check("strobe_kept", kb_data, 8'h8D);
    ack();
    key(1'b1, 8'h74, 1'b0);
    key(1'b0, 8'h14, 1'b0);
    key(1'b0, 8'h23, 1'b1); @(negedge clk);
    check("ctrl_released", kb_data, 8'hE4);
    ack();
    key(1'b0, 8'h23, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].shift) key(1'b0, 8'h12, 1'b1);
      key(vecs[i].ext, vecs[i].code, 1'b1); @(negedge clk);
      check($sformatf("map_%0d_%h", i, vecs[i].code), kb_data, vecs[i].exp);
      ack();
      key(vecs[i].ext, vecs[i].code, 1'b0);
      if (vecs[i].shift) key(1'b0, 8'h12, 1'b0);
    end

    // Hold 'a' and ack each delivery; ack lands on the third delivery's edge
    pred = -1;
    key(1'b0, 8'h1C, 1'b1);
    for (int i = 0; i < 76; i++) begin
      @(negedge clk);
      key_ack = 1'b0;
      if (i == pred) check("ack_vs_repeat", kb_data[7], 1'b1);
      if (kb_data[7]) begin
        hits.push_back(i);
        key_ack = 1'b1;
        if (hits.size() == 2) pred = i + 20;
      end
      if (i == pred - 1) key_ack = 1'b1;
    end
    key_ack = 1'b0;
    check("hold_down", kb_down, 1'b1);
    for (int k = 0; k < 4; k++) t[k] = (k < hits.size()) ? hits[k] : -100;
    check("first_delivery", t[0], 0);
`ifdef ABC80_KBD_TYPEMATIC_EN
    check("n_deliveries", hits.size(), 4);
    check("delay_window", (t[1] >= 21 && t[1] <= 30), 1'b1);
    check("rate_gap1", t[2] - t[1], 20);
    check("rate_gap2", t[3] - t[2], 20);
`else
    check("n_deliveries", hits.size(), 1);
`endif
    key(1'b0, 8'h1C, 1'b0);
    check("hold_break_down", kb_down, 1'b0);
    repeat (40) @(negedge clk);
    check("no_repeat_after_break", kb_data, 8'h61);

    // Asynchronous reset while held with strobe pending
    key(1'b0, 8'h1C, 1'b1); @(negedge clk);
    check("pre_reset", kb_data, 8'hE1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_data", kb_data, 8'h00);
    check("async_rst_down", kb_down, 1'b0);
    @(negedge clk); rst = 1'b0;
    key(1'b0, 8'h1C, 1'b0);
    repeat (40) @(negedge clk);
    check("post_reset_quiet", kb_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
